counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// Run-control sequencer for an external up/down counter: prescaled step pulses,
// once/ping-pong/free-run modes, with start/stop handshakes.
module counter_sequencer #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] lo_lim,
  input  logic [CNT_W-1:0] hi_lim,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_enable,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_DOWN_ONCE = 2'b01;
  localparam logic [1:0] MODE_PING_PONG = 2'b10;
  localparam logic [1:0] MODE_FREE_RUN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [PRE_W-1:0]   pre_q;
  logic [PRE_W-1:0]   pre_d;
  logic [1:0]         mode_q;
  logic [1:0]         mode_d;
  logic [CNT_W-1:0]   lo_q;
  logic [CNT_W-1:0]   lo_d;
  logic [CNT_W-1:0]   hi_q;
  logic [CNT_W-1:0]   hi_d;
  logic               enable_d;
  logic               up_d;
  logic               busy_d;
  logic               done_d;
  logic               err_d;
  logic               tick;

  assign state = state_q;
  assign tick  = (pre_q == PRE_LAST);

  // Next-state, prescaler and pulse decode
  always_comb begin
    state_d  = state_q;
    pre_d    = '0;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if ((mode == MODE_FREE_RUN) || (lo_lim <= hi_lim)) begin
            state_d = (mode == MODE_DOWN_ONCE) ? RUN_DOWN : RUN_UP;
            mode_d  = mode;
            lo_d    = lo_lim;
            hi_d    = hi_lim;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN_UP: begin
        if (tick) begin
          if ((mode_q == MODE_FREE_RUN) || (count < hi_q)) begin
            enable_d = 1'b1;
          end else if (mode_q == MODE_PING_PONG) begin
            state_d  = RUN_DOWN;
            enable_d = (lo_q != hi_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RUN_DOWN: begin
        if (tick) begin
          if (count > lo_q) begin
            enable_d = 1'b1;
          end else if (mode_q == MODE_PING_PONG) begin
            state_d  = RUN_UP;
            enable_d = (lo_q != hi_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // stop wins over any coincident tick or start
    if (stop) begin
      state_d  = IDLE;
      enable_d = 1'b0;
      done_d   = 1'b0;
    end

    // Prescaler only advances while a run continues; any run entry restarts it at 0
    if ((state_q != IDLE) && (state_d != IDLE)) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    up_d   = (state_d != RUN_DOWN);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      mode_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      cnt_enable <= 1'b0;
      cnt_up     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      mode_q     <= mode_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_enable <= enable_d;
      cnt_up     <= up_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule
